// File: rtl/lfsr16_checker.sv
// Receive-side checker for the 16-state augmented LFSR: hunts for a legal word, verifies,
// then flywheels the prediction while locked and reports index/mismatch per sample.
module lfsr16_checker #(
  parameter int LOCK_N   = 2,
  parameter int UNLOCK_N = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       in_data,
  output logic             locked,
  output logic             out_valid,
  output logic [3:0]       index,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_LIM   = 4'(LOCK_N);
  localparam logic [3:0]       UNLOCK_LIM = 4'(UNLOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1'b1);

  // Successor word; bit 4 of the current word never feeds the next word.
  function automatic logic [4:0] next_word(input logic [3:0] s);
    next_word = {s, s[3] ^ s[0] ^ ~|s[2:0]};
  endfunction

  // Returns {legal, position} of a received word.
  function automatic logic [4:0] seq_lookup(input logic [4:0] w);
    case (w)
      5'b10000: seq_lookup = {1'b1, 4'd0};
      5'b00001: seq_lookup = {1'b1, 4'd1};
      5'b00011: seq_lookup = {1'b1, 4'd2};
      5'b00111: seq_lookup = {1'b1, 4'd3};
      5'b01111: seq_lookup = {1'b1, 4'd4};
      5'b11110: seq_lookup = {1'b1, 4'd5};
      5'b11101: seq_lookup = {1'b1, 4'd6};
      5'b11010: seq_lookup = {1'b1, 4'd7};
      5'b10101: seq_lookup = {1'b1, 4'd8};
      5'b01011: seq_lookup = {1'b1, 4'd9};
      5'b10110: seq_lookup = {1'b1, 4'd10};
      5'b01100: seq_lookup = {1'b1, 4'd11};
      5'b11001: seq_lookup = {1'b1, 4'd12};
      5'b10010: seq_lookup = {1'b1, 4'd13};
      5'b00100: seq_lookup = {1'b1, 4'd14};
      5'b01000: seq_lookup = {1'b1, 4'd15};
      default:  seq_lookup = {1'b0, 4'd0};
    endcase
  endfunction

  state_t           state, state_next;
  logic [4:0]       expected, expected_next;
  logic [3:0]       match_cnt, match_next;
  logic [3:0]       miss_cnt, miss_next;
  logic             locked_next, out_valid_next, err_next;
  logic [3:0]       index_next;
  logic [ERR_W-1:0] err_count_next;
  logic [4:0]       in_info, exp_info;
  logic             in_legal;

  assign in_info  = seq_lookup(in_data);
  assign exp_info = seq_lookup(expected);
  assign in_legal = in_info[4];

  // Next-state and registered-output computation for one sample.
  always_comb begin
    state_next     = state;
    expected_next  = expected;
    match_next     = match_cnt;
    miss_next      = miss_cnt;
    out_valid_next = 1'b0;
    err_next       = 1'b0;
    index_next     = index;
    err_count_next = err_count;

    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_legal) begin
            expected_next = next_word(in_data[3:0]);
            match_next    = 4'd1;
            miss_next     = 4'd0;
            if (LOCK_LIM == 4'd1) begin
              state_next = LOCKED;
            end else begin
              state_next = VERIFY;
            end
          end else begin
            state_next = HUNT;
          end
        end
        VERIFY: begin
          if (in_data == expected) begin
            expected_next = next_word(in_data[3:0]);
            match_next    = match_cnt + 4'd1;
            if (match_cnt + 4'd1 >= LOCK_LIM) begin
              state_next = LOCKED;
              miss_next  = 4'd0;
            end else begin
              state_next = VERIFY;
            end
          end else if (in_legal) begin
            expected_next = next_word(in_data[3:0]);
            match_next    = 4'd1;
          end else begin
            state_next = HUNT;
            match_next = 4'd0;
          end
        end
        LOCKED: begin
          out_valid_next = 1'b1;
          index_next     = exp_info[3:0];
          // Flywheel: prediction advances regardless of what arrived.
          expected_next  = next_word(expected[3:0]);
          if (in_data == expected) begin
            miss_next = 4'd0;
          end else begin
            err_next = 1'b1;
            if (err_count != ERR_MAX) begin
              err_count_next = err_count + ERR_ONE;
            end else begin
              err_count_next = err_count;
            end
            if (miss_cnt + 4'd1 >= UNLOCK_LIM) begin
              state_next = HUNT;
              miss_next  = 4'd0;
              match_next = 4'd0;
            end else begin
              miss_next = miss_cnt + 4'd1;
            end
          end
        end
        default: begin
          state_next    = HUNT;
          expected_next = 5'b10000;
          match_next    = 4'd0;
          miss_next     = 4'd0;
        end
      endcase
    end else begin
      state_next = state;
    end

    locked_next = (state_next == LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      expected  <= 5'b10000;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      out_valid <= 1'b0;
      index     <= 4'd0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_next;
      expected  <= expected_next;
      match_cnt <= match_next;
      miss_cnt  <= miss_next;
      locked    <= locked_next;
      out_valid <= out_valid_next;
      index     <= index_next;
      err       <= err_next;
      err_count <= err_count_next;
    end
  end

endmodule

// File: tb/tb_lfsr16_checker.sv
// Directed vector table plus randomized stream, compared against an index-based reference model.
module tb_lfsr16_checker;

  localparam int LOCK_N   = 2;
  localparam int UNLOCK_N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = 5'd0;
  logic       locked, out_valid, err, locked2, out_valid2, err2;
  logic [3:0] index, index2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr16_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .out_valid(out_valid), .index(index), .err(err),
    .err_count(err_count)
  );

  lfsr16_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .locked(locked2), .out_valid(out_valid2), .index(index2), .err(err2),
    .err_count(err_count2)
  );

  logic [4:0] seq [16] = '{5'b10000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11110,
                           5'b11101, 5'b11010, 5'b10101, 5'b01011, 5'b10110, 5'b01100,
                           5'b11001, 5'b10010, 5'b00100, 5'b01000};

  // Reference model: mode 0=hunt 1=verify 2=locked; prediction kept as a sequence position.
  int m_mode, m_pos, m_match, m_miss, m_errc, m_errc2;
  int m_locked, m_ov, m_idx, m_err;

  function automatic int find_pos(input logic [4:0] w);
    for (int i = 0; i < 16; i++) if (seq[i] == w) return i;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [4:0] d);
    int p;
    if (r) begin
      m_mode = 0; m_pos = 0; m_match = 0; m_miss = 0; m_errc = 0; m_errc2 = 0;
      m_ov = 0; m_idx = 0; m_err = 0;
    end else begin
      m_ov = 0; m_err = 0;
      if (v) begin
        p = find_pos(d);
        if (m_mode == 0) begin
          if (p >= 0) begin
            m_pos = (p + 1) % 16; m_match = 1;
            m_mode = (LOCK_N == 1) ? 2 : 1;
            m_miss = 0;
          end
        end else if (m_mode == 1) begin
          if (p == m_pos) begin
            m_pos = (p + 1) % 16; m_match++;
            if (m_match >= LOCK_N) begin m_mode = 2; m_miss = 0; end
          end else if (p >= 0) begin
            m_pos = (p + 1) % 16; m_match = 1;
          end else begin
            m_mode = 0;
          end
        end else begin
          m_ov = 1; m_idx = m_pos;
          if (p != m_pos) begin
            m_err = 1;
            if (m_errc < 255) m_errc++;
            if (m_errc2 < 3) m_errc2++;
            m_miss++;
            if (m_miss >= UNLOCK_N) m_mode = 0;
          end else begin
            m_miss = 0;
          end
          m_pos = (m_pos + 1) % 16;
        end
      end
    end
    m_locked = (m_mode == 2) ? 1 : 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle, advances the model, and compares both instances after the edge.
  task automatic step(input logic r, input logic v, input logic [4:0] d);
    rst = r; in_valid = v; in_data = d;
    model_step(r, v, d);
    @(posedge clk);
    #1;
    chk("locked", int'(locked), m_locked);
    chk("out_valid", int'(out_valid), m_ov);
    if (m_ov == 1) chk("index", int'(index), m_idx);
    chk("err", int'(err), m_err);
    chk("err_count", int'(err_count), m_errc);
    chk("err_count_w2", int'(err_count2), m_errc2);
    chk("locked_w2", int'(locked2), m_locked);
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [4:0] d;
    logic       l;
    logic       ov;
    logic [3:0] idx;
    logic       e;
    logic [7:0] ec;
    logic [1:0] ec2;
  } vec_t;

  vec_t vecs [20];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 4'd0,  1'b0, 8'd0, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, 5'b10000, 1'b0, 1'b0, 4'd0,  1'b0, 8'd0, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 5'b00001, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0, 2'd0};
    vecs[3]  = '{1'b0, 1'b1, 5'b00011, 1'b1, 1'b1, 4'd2,  1'b0, 8'd0, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 5'b00110, 1'b1, 1'b1, 4'd3,  1'b1, 8'd1, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 5'b01111, 1'b1, 1'b1, 4'd4,  1'b0, 8'd1, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 5'b01111, 1'b1, 1'b0, 4'd4,  1'b0, 8'd1, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 5'b11110, 1'b1, 1'b1, 4'd5,  1'b0, 8'd1, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b1, 4'd6,  1'b1, 8'd2, 2'd2};
    vecs[9]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b1, 4'd7,  1'b1, 8'd3, 2'd3};
    vecs[10] = '{1'b0, 1'b1, 5'b00000, 1'b0, 1'b1, 4'd8,  1'b1, 8'd4, 2'd3};
    vecs[11] = '{1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 4'd8,  1'b0, 8'd4, 2'd3};
    vecs[12] = '{1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 4'd8,  1'b0, 8'd4, 2'd3};
    vecs[13] = '{1'b0, 1'b1, 5'b01100, 1'b0, 1'b0, 4'd8,  1'b0, 8'd4, 2'd3};
    vecs[14] = '{1'b0, 1'b1, 5'b11001, 1'b1, 1'b0, 4'd8,  1'b0, 8'd4, 2'd3};
    vecs[15] = '{1'b0, 1'b1, 5'b10010, 1'b1, 1'b1, 4'd13, 1'b0, 8'd4, 2'd3};
    vecs[16] = '{1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 4'd14, 1'b0, 8'd4, 2'd3};
    vecs[17] = '{1'b0, 1'b1, 5'b01000, 1'b1, 1'b1, 4'd15, 1'b0, 8'd4, 2'd3};
    vecs[18] = '{1'b0, 1'b1, 5'b10000, 1'b1, 1'b1, 4'd0,  1'b0, 8'd4, 2'd3};
    vecs[19] = '{1'b1, 1'b1, 5'b00001, 1'b0, 1'b0, 4'd0,  1'b0, 8'd0, 2'd0};

    step(1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].l));
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].ov));
      chk($sformatf("vec%0d_index", i), int'(index), int'(vecs[i].idx));
      chk($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].e));
      chk($sformatf("vec%0d_err_count", i), int'(err_count), int'(vecs[i].ec));
      chk($sformatf("vec%0d_err_count_w2", i), int'(err_count2), int'(vecs[i].ec2));
    end

    // Lock, then alternate valid/idle: idle cycles must never pulse out_valid.
    step(1'b0, 1'b1, seq[7]);
    step(1'b0, 1'b1, seq[8]);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, seq[(9 + k) % 16]);
      chk("t5_index", int'(index), (9 + k) % 16);
      step(1'b0, 1'b0, seq[(10 + k) % 16]);
      chk("t5_idle_ov", int'(out_valid), 0);
    end

    // Randomized stream: mostly in-sequence words with injected errors, idles and resets.
    begin
      int tx;
      int roll;
      logic [4:0] w;
      tx = 0;
      for (int n = 0; n < 4000; n++) begin
        roll = int'($urandom_range(0, 99));
        if (roll < 1) begin
          step(1'b1, 1'b0, 5'd0);
        end else if (roll < 15) begin
          w = 5'($urandom);
          step(1'b0, 1'b0, w);
        end else if (roll < 25) begin
          w = 5'($urandom);
          step(1'b0, 1'b1, w);
          tx = (tx + 1) % 16;
        end else if (roll < 28) begin
          tx = int'($urandom_range(0, 15));
          step(1'b0, 1'b1, seq[tx]);
          tx = (tx + 1) % 16;
        end else begin
          step(1'b0, 1'b1, seq[tx]);
          tx = (tx + 1) % 16;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
